// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined RV32I decode stage with register bank and ID/EX register
//
// Decodes the instruction presented by IF, reads rs1/rs2 from an internal
// register bank, resolves JAL/JALR targets and captures the decoded fields
// into an ID/EX register. Both sides use valid/ready handshakes. The stage
// stalls on load-use hazards, inserts bubbles and honours a flush.
//
// Optional feature macro: ID_WB_BYPASS_EN
//   defined   : writeback data is forwarded to a same-cycle read of that register
//   undefined : a same-cycle writeback to a used source register stalls ID one cycle
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   instr_valid_i / instr_ready_o    IF -> ID handshake
//   instruction_i, program_count_i   instruction word and its PC
//   flush_i                          kill ID and the ID/EX register
//   ex_ready_i                       EX accepts ID/EX contents
//   ex_rd_addr_i, ex_is_load_i       EX-stage destination / load flag (hazard)
//   wb_we_i, wb_waddr_i, wb_wdata_i  register bank writeback port
//   id_valid_o ... illegal_o         registered ID/EX fields
//   jump_taken_o, jump_addr_o        combinational jump redirect to IF

module id_stage_pipe #(
    parameter int              XLEN       = 32,
    parameter int              REG_ADDR_W = 5,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [31:0]           instruction_i,
    input  logic [XLEN-1:0]       program_count_i,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_is_load_i,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]       wb_wdata_i,
    output logic                  id_valid_o,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    output logic [XLEN-1:0]       imm_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  reg_we_o,
    output logic                  is_load_o,
    output logic [XLEN-1:0]       pc_o,
    output logic                  illegal_o,
    output logic                  jump_taken_o,
    output logic [XLEN-1:0]       jump_addr_o
);

    localparam int DEPTH = 2 ** REG_ADDR_W;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Immediates are formed at 32 bits and sign-extended to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [31:0]           imm_i32;
    logic [31:0]           imm_s32;
    logic [31:0]           imm_b32;
    logic [31:0]           imm_u32;
    logic [31:0]           imm_j32;

    assign opcode   = instruction_i[6:0];
    assign rs1_addr = REG_ADDR_W'(instruction_i[19:15]);
    assign rs2_addr = REG_ADDR_W'(instruction_i[24:20]);
    assign rd_addr  = REG_ADDR_W'(instruction_i[11:7]);

    assign imm_i32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_b32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                      instruction_i[30:25], instruction_i[11:8], 1'b0};
    assign imm_u32 = {instruction_i[31:12], 12'b0};
    assign imm_j32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                      instruction_i[20], instruction_i[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic        dec_legal;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        dec_writes_rd;
    logic        dec_is_load;
    logic        dec_is_jal;
    logic        dec_is_jalr;
    logic [31:0] dec_imm32;

    always_comb begin
        dec_legal     = 1'b1;
        dec_use_rs1   = 1'b0;
        dec_use_rs2   = 1'b0;
        dec_writes_rd = 1'b0;
        dec_is_load   = 1'b0;
        dec_is_jal    = 1'b0;
        dec_is_jalr   = 1'b0;
        dec_imm32     = 32'h0;
        unique case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_writes_rd = 1'b1;
                dec_imm32     = imm_u32;
            end
            OP_JAL: begin
                dec_writes_rd = 1'b1;
                dec_is_jal    = 1'b1;
                dec_imm32     = imm_j32;
            end
            OP_JALR: begin
                dec_use_rs1   = 1'b1;
                dec_writes_rd = 1'b1;
                dec_is_jalr   = 1'b1;
                dec_imm32     = imm_i32;
            end
            OP_BRANCH: begin
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_imm32   = imm_b32;
            end
            OP_LOAD: begin
                dec_use_rs1   = 1'b1;
                dec_writes_rd = 1'b1;
                dec_is_load   = 1'b1;
                dec_imm32     = imm_i32;
            end
            OP_STORE: begin
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_imm32   = imm_s32;
            end
            OP_IMM, OP_SYSTEM: begin
                dec_use_rs1   = 1'b1;
                dec_writes_rd = 1'b1;
                dec_imm32     = imm_i32;
            end
            OP_REG: begin
                dec_use_rs1   = 1'b1;
                dec_use_rs2   = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OP_FENCE: begin
                dec_imm32 = imm_i32;
            end
            default: begin
                // Unknown opcodes travel down the pipe as harmless NOPs
                // tagged illegal so EX can raise the exception.
                dec_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register bank: entry 0 is never written so it always reads zero.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] bank [DEPTH];
    logic            wb_active;

    assign wb_active = wb_we_i & (wb_waddr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wb_active) begin
            bank[wb_waddr_i] <= wb_wdata_i;
        end
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            wb_hits_rs1;
    logic            wb_hits_rs2;

    assign wb_hits_rs1 = wb_active & (wb_waddr_i == rs1_addr);
    assign wb_hits_rs2 = wb_active & (wb_waddr_i == rs2_addr);

`ifdef ID_WB_BYPASS_EN
    assign rs1_val = (rs1_addr == '0) ? '0 : (wb_hits_rs1 ? wb_wdata_i : bank[rs1_addr]);
    assign rs2_val = (rs2_addr == '0) ? '0 : (wb_hits_rs2 ? wb_wdata_i : bank[rs2_addr]);
`else
    assign rs1_val = (rs1_addr == '0) ? '0 : bank[rs1_addr];
    assign rs2_val = (rs2_addr == '0) ? '0 : bank[rs2_addr];
`endif

    // ------------------------------------------------------------------
    // Hazards and handshakes
    // ------------------------------------------------------------------
    logic load_hazard;
    logic wb_hazard;
    logic hazard;
    logic adv;
    logic accept;

    // Only an instruction still sitting in ID/EX can be the load in EX that
    // feeds us, hence the id_valid_o qualifier.
    assign load_hazard = ex_is_load_i & id_valid_o & (ex_rd_addr_i != '0) &
                         ((dec_use_rs1 & (ex_rd_addr_i == rs1_addr)) |
                          (dec_use_rs2 & (ex_rd_addr_i == rs2_addr)));

`ifdef ID_WB_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    // Without forwarding, wait one cycle so the bank holds the new value.
    assign wb_hazard = (dec_use_rs1 & wb_hits_rs1) | (dec_use_rs2 & wb_hits_rs2);
`endif

    assign hazard        = load_hazard | wb_hazard;
    assign adv           = ~id_valid_o | ex_ready_i;
    assign instr_ready_o = adv & ~hazard & ~flush_i;
    assign accept        = instr_valid_i & instr_ready_o;

    // ------------------------------------------------------------------
    // Jump resolution
    // ------------------------------------------------------------------
    logic [XLEN-1:0] jal_target;
    logic [XLEN-1:0] jalr_sum;

    assign jal_target   = program_count_i + sext32(imm_j32);
    assign jalr_sum     = rs1_val + sext32(imm_i32);
    assign jump_taken_o = accept & (dec_is_jal | dec_is_jalr);
    assign jump_addr_o  = dec_is_jal ? jal_target : {jalr_sum[XLEN-1:1], 1'b0};

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_o <= 1'b0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            rd_addr_o  <= '0;
            reg_we_o   <= 1'b0;
            is_load_o  <= 1'b0;
            pc_o       <= RESET_PC;
            illegal_o  <= 1'b0;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
            reg_we_o   <= 1'b0;
            is_load_o  <= 1'b0;
        end else if (adv) begin
            id_valid_o <= accept;
            if (accept) begin
                rs1_data_o <= rs1_val;
                rs2_data_o <= rs2_val;
                imm_o      <= sext32(dec_imm32);
                rd_addr_o  <= rd_addr;
                reg_we_o   <= dec_legal & dec_writes_rd & (rd_addr != '0);
                is_load_o  <= dec_is_load;
                pc_o       <= program_count_i;
                illegal_o  <= ~dec_legal;
            end else begin
                // Bubble: operand fields are left stale but must not act.
                reg_we_o  <= 1'b0;
                is_load_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - self-checking scoreboard bench for id_stage_pipe
module tb_id_stage_pipe;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
`ifdef ID_WB_BYPASS_EN
    localparam int WB_STALL = 0;
`else
    localparam int WB_STALL = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instruction_i;
    logic [31:0] program_count_i;
    logic        flush_i;
    logic        ex_ready_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_is_load_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        id_valid_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_addr_o;
    logic        reg_we_o;
    logic        is_load_o;
    logic [31:0] pc_o;
    logic        illegal_o;
    logic        jump_taken_o;
    logic [31:0] jump_addr_o;

    id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instruction_i(instruction_i), .program_count_i(program_count_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i),
        .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
        .id_valid_o(id_valid_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .rd_addr_o(rd_addr_o), .reg_we_o(reg_we_o),
        .is_load_o(is_load_o), .pc_o(pc_o), .illegal_o(illegal_o),
        .jump_taken_o(jump_taken_o), .jump_addr_o(jump_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic we, input logic ld,
                                input logic [31:0] pc, input logic ill);
        exp_t e;
        e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd;
        e.we = we; e.ld = ld; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    // Each ID/EX transfer to EX is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && id_valid_o === 1'b1 && ex_ready_i === 1'b1) begin
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL sb_underflow: observed unexpected output pc 0x%0h expected none", pc_o);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_rs1", rs1_data_o, e.rs1);
                chk("out_rs2", rs2_data_o, e.rs2);
                chk("out_imm", imm_o, e.imm);
                chk("out_rd", rd_addr_o, e.rd);
                chk("out_we", reg_we_o, e.we);
                chk("out_load", is_load_o, e.ld);
                chk("out_pc", pc_o, e.pc);
                chk("out_illegal", illegal_o, e.ill);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_we_i = 1'b1; wb_waddr_i = a; wb_wdata_i = d;
        if (a != 5'd0) model[a] = d;
        tick();
        wb_we_i = 1'b0;
    endtask

    // Presents one instruction, pushes its expectation and waits (bounded)
    // for acceptance; a writeback driven alongside lasts only one cycle.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input int exp_stalls, input exp_t e,
                        output logic jt, output logic [31:0] ja);
        int stalls;
        bit acc;
        stalls = 0; acc = 0; jt = 1'b0; ja = 32'h0;
        instruction_i = ins; program_count_i = pc; instr_valid_i = 1'b1;
        sb.push_back(e);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (instr_ready_o === 1'b1) begin
                acc = 1; jt = jump_taken_o; ja = jump_addr_o;
                break;
            end
            stalls++;
            tick();
            wb_we_i = 1'b0;
        end
        chk("accepted", acc, 1);
        chk("stall_cycles", stalls, exp_stalls);
        tick();
        instr_valid_i = 1'b0; wb_we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        jt;
        logic [31:0] ja;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst_n = 1'b0; instr_valid_i = 1'b0; instruction_i = 32'h0; program_count_i = 32'h0;
        flush_i = 1'b0; ex_ready_i = 1'b1; ex_rd_addr_i = 5'd0; ex_is_load_i = 1'b0;
        wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'h0;
        repeat (3) tick();
        chk("rst_valid", id_valid_o, 0);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_we", reg_we_o, 0);
        chk("rst_jump", jump_taken_o, 0);
        rst_n = 1'b1;
        tick();

        // Basic decode: ADDI x2,x1,-4 with x1=0x10
        wb(5'd1, 32'h10);
        send(32'hFFC08113, 32'h100, 0,
             mk(model[1], model[28], 32'hFFFFFFFC, 5'd2, 1, 0, 32'h100, 0), jt, ja);
        chk("addi_no_jump", jt, 0);
        chk("addi_valid", id_valid_o, 1);
        chk("addi_rd", rd_addr_o, 2);
        chk("addi_pc", pc_o, 32'h100);

        // Load-use: ADD x3,x2,x1 while EX loads x2
        ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd2;
        instruction_i = 32'h001101B3; program_count_i = 32'h104; instr_valid_i = 1'b1;
        sb.push_back(mk(model[2], model[1], 32'h0, 5'd3, 1, 0, 32'h104, 0));
        @(negedge clk);
        chk("lu_ready_low", instr_ready_o, 0);
        tick();
        chk("lu_bubble_valid", id_valid_o, 0);
        chk("lu_bubble_we", reg_we_o, 0);
        @(negedge clk);
        chk("lu_ready_high", instr_ready_o, 1);
        tick();
        chk("lu_accepted", id_valid_o, 1);
        ex_is_load_i = 1'b0; instr_valid_i = 1'b0;

        // Backpressure: hold ADDI x5,x0,7 in ID/EX for three cycles
        send(32'h00700293, 32'h108, 0,
             mk(32'h0, model[7], 32'h7, 5'd5, 1, 0, 32'h108, 0), jt, ja);
        ex_ready_i = 1'b0;
        instruction_i = 32'h00900313; program_count_i = 32'h10C; instr_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", instr_ready_o, 0);
            chk("bp_valid", id_valid_o, 1);
            chk("bp_rd", rd_addr_o, 5);
            chk("bp_imm", imm_o, 32'h7);
            chk("bp_pc", pc_o, 32'h108);
            tick();
        end
        ex_ready_i = 1'b1;
        send(32'h00900313, 32'h10C, 0,
             mk(32'h0, model[9], 32'h9, 5'd6, 1, 0, 32'h10C, 0), jt, ja);

        // JALR x0,1(x1) with x1=0x2003
        wb(5'd1, 32'h2003);
        send(32'h00108067, 32'h200, 0,
             mk(model[1], model[1], 32'h1, 5'd0, 0, 0, 32'h200, 0), jt, ja);
        chk("jalr_taken", jt, 1);
        chk("jalr_addr", ja, 32'h2004);

        // JAL x1,-8 at 0x100
        send(32'hFF9FF0EF, 32'h100, 0,
             mk(model[31], model[25], 32'hFFFFFFF8, 5'd1, 1, 0, 32'h100, 0), jt, ja);
        chk("jal_taken", jt, 1);
        chk("jal_addr", ja, 32'hF8);

        // Writeback of x4 in the same cycle ADD x7,x4,x0 reads it
        wb_we_i = 1'b1; wb_waddr_i = 5'd4; wb_wdata_i = 32'hAB;
        model[4] = 32'hAB;
        send(32'h000203B3, 32'h104, WB_STALL,
             mk(32'hAB, 32'h0, 32'h0, 5'd7, 1, 0, 32'h104, 0), jt, ja);
        tick();

        // Flush kills an instruction held in ID/EX and refuses the incoming one
        ex_ready_i = 1'b0;
        instruction_i = 32'h00700293; program_count_i = 32'h1F0; instr_valid_i = 1'b1;
        tick();
        chk("fl_pre_valid", id_valid_o, 1);
        flush_i = 1'b1; program_count_i = 32'h1F4;
        @(negedge clk);
        chk("fl_ready", instr_ready_o, 0);
        tick();
        chk("fl_valid", id_valid_o, 0);
        flush_i = 1'b0; instr_valid_i = 1'b0; ex_ready_i = 1'b1;
        tick();

        // Illegal opcode flows as a normal instruction
        send(32'h000002FF, 32'h300, 0,
             mk(32'h0, 32'h0, 32'h0, 5'd5, 0, 0, 32'h300, 1), jt, ja);
        chk("ill_no_jump", jt, 0);
        tick();

        // Asynchronous reset while an instruction is held in ID/EX
        wb(5'd5, 32'h55);
        ex_ready_i = 1'b0;
        instruction_i = 32'h00700293; program_count_i = 32'h400; instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        chk("mr_pre_valid", id_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", id_valid_o, 0);
        chk("mr_pc", pc_o, RST_PC);
        chk("mr_imm", imm_o, 32'h0);
        chk("mr_rd", rd_addr_o, 0);
        chk("mr_we", reg_we_o, 0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        repeat (2) tick();
        rst_n = 1'b1; ex_ready_i = 1'b1;
        tick();
        send(32'h00528433, 32'h404, 0,
             mk(model[5], model[5], 32'h0, 5'd8, 1, 0, 32'h404, 0), jt, ja);
        repeat (2) tick();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, pipelined successor to the combinational decode stage.
- Decodes RV32I-class instructions, reads an internal register bank and resolves JAL/JALR targets in ID.
- Registers all decoded fields into an ID/EX output register with valid/ready handshakes on both sides.
- Adds load-use hazard stalling, flush and bubble insertion. Sits between the IF stage and the EX stage.

Parameters:
- XLEN, 32, datapath and register width in bits.
- REG_ADDR_W, 5, register address width; bank depth is 2**REG_ADDR_W, with register 0 hardwired to zero.
- RESET_PC, 0, value driven on pc_o while no instruction has been captured.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid_i  in  1  IF presents instruction_i/program_count_i
instr_ready_o  out  1  ID accepts the instruction this cycle
instruction_i  in  32  raw instruction word
program_count_i  in  XLEN  PC of instruction_i
flush_i  in  1  kill the instruction in ID and the ID/EX register
ex_ready_i  in  1  EX can take the ID/EX register contents
ex_rd_addr_i  in  REG_ADDR_W  destination register of the instruction in EX
ex_is_load_i  in  1  instruction in EX is a load
wb_we_i  in  1  writeback enable
wb_waddr_i  in  REG_ADDR_W  writeback address
wb_wdata_i  in  XLEN  writeback data
id_valid_o  out  1  ID/EX register holds a valid instruction
rs1_data_o  out  XLEN  registered rs1 operand
rs2_data_o  out  XLEN  registered rs2 operand
imm_o  out  XLEN  registered sign-extended immediate (I/S/B/U/J, selected by opcode)
rd_addr_o  out  REG_ADDR_W  registered destination register
reg_we_o  out  1  registered writeback enable; 0 when rd==0
is_load_o  out  1  registered load flag
pc_o  out  XLEN  registered PC
illegal_o  out  1  registered illegal-opcode flag
jump_taken_o  out  1  combinational; JAL/JALR accepted this cycle
jump_addr_o  out  XLEN  combinational jump target

Behaviour:
- Reset (async, rst_n=0): id_valid_o, reg_we_o, is_load_o, illegal_o, rs1/rs2_data_o, imm_o and rd_addr_o go to 0; pc_o=RESET_PC; all bank registers are 0. jump_taken_o=0 because no instruction is accepted. Release is synchronous to clk.
- Register bank: synchronous write on the clk edge when wb_we_i=1 and wb_waddr_i!=0. Writes to address 0 are ignored. Reads are combinational.
- Load-use hazard: hazard=ex_is_load_i & id_valid_o & (ex_rd_addr_i!=0) & (ex_rd_addr_i matches a *used* rs1 or rs2). U/J types use neither source; I-type and load use rs1 only.
- Handshakes:
  - adv = ~id_valid_o | ex_ready_i.
  - instr_ready_o = adv & ~hazard & ~flush_i.
  - accept = instr_valid_i & instr_ready_o.
- ID/EX register update on the clk edge:
  - flush_i=1 → id_valid_o=0; the incoming instruction is dropped.
  - Otherwise, if adv: id_valid_o=accept, and fields load from the decode. On a bubble (adv & ~accept) fields may hold, but reg_we_o and is_load_o are forced to 0.
  - Otherwise (EX stalled): all outputs hold.
- Jumps:
  - jump_taken_o = accept & (JAL|JALR).
  - JAL target = program_count_i + J-immediate.
  - JALR target = (rs1 + I-immediate) with bit0 cleared.
  - rs1 is the bank value (or bypassed value); all addition wraps modulo 2**XLEN.
  - The upstream fetch redirects on jump_taken_o; ID does not self-flush.
- Illegal opcode: accepted as a normal instruction with illegal_o=1 and reg_we_o=0.
- Simultaneous events: flush_i dominates hazard and accept. A writeback and a read of the same register in one cycle are governed by the optional feature.
- Reset mid-operation: the in-flight instruction is discarded with no partial state.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: a read address equal to wb_waddr_i with wb_we_i=1 (address !=0) returns wb_wdata_i in the same cycle.
- Undefined: no bypass. The hazard condition is extended with wb_we_i & (wb_waddr_i!=0) & (wb_waddr_i matches a used rs), so ID stalls one cycle and reads the written value next cycle.

Test Plan:
- Reset: hold rst_n=0 mid-stream with id_valid_o=1 → all outputs clear asynchronously; pc_o=RESET_PC; reading x5 later returns 0.
- Basic decode: wb x1=0x10, then ADDI x2,x1,-4 (0xFFC08113) at PC 0x100 → next cycle id_valid_o=1, rs1_data_o=0x10, imm_o=0xFFFFFFFC, rd_addr_o=2, reg_we_o=1, pc_o=0x100.
- Load-use: ex_is_load_i=1, ex_rd_addr_i=2, instruction ADD x3,x2,x1 → instr_ready_o=0 for that cycle, one bubble with id_valid_o=0 and reg_we_o=0; accepted the following cycle.
- Backpressure: ex_ready_i=0 for 3 cycles with id_valid_o=1 → all outputs stable, instr_ready_o=0; on ex_ready_i=1 the next instruction is captured.
- JALR: x1=0x2003, JALR x0,1(x1) → jump_taken_o=1 and jump_addr_o=0x2004 in the accept cycle. JAL at PC 0x100 with offset -8 → jump_addr_o=0xF8.
- Bypass/flush: wb x4=0xAB in the same cycle ADD reads x4 → with ID_WB_BYPASS_EN, rs1_data_o=0xAB with no stall; without the macro, one stall cycle then 0xAB. Asserting flush_i with instr_valid_i=1 → instr_ready_o=0 and id_valid_o=0 next cycle.
